// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment scan scheduler.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_state_t;

  typedef struct packed {
    logic [3:0] data;
    logic       dp;
  } seg_entry_t;

  // Returns {CA,CB,CC,CD,CE,CF,CG}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// Two-requester digit-buffer write bus for seg_scan_scheduler.
interface seg_scan_scheduler_if;
  import seg_scan_pkg::*;

  logic             a_valid;
  logic             a_ready;
  logic [IDX_W-1:0] a_idx;
  logic [3:0]       a_data;
  logic             a_dp;

  logic             b_valid;
  logic             b_ready;
  logic [IDX_W-1:0] b_idx;
  logic [3:0]       b_data;
  logic             b_dp;

  modport master (
    output a_valid, a_idx, a_data, a_dp,
    output b_valid, b_idx, b_data, b_dp,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_idx, a_data, a_dp,
    input  b_valid, b_idx, b_data, b_dp,
    output a_ready, b_ready
  );
endinterface

// File: rtl/seg_write_arbiter.sv
// Two-port round-robin write arbiter; grants are combinational from the valids.
module seg_write_arbiter
  import seg_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [3:0]       a_data,
  input  logic             a_dp,
  input  logic             b_valid,
  input  logic [IDX_W-1:0] b_idx,
  input  logic [3:0]       b_data,
  input  logic             b_dp,
  output logic             grant_a,
  output logic             grant_b,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [3:0]       wr_data,
  output logic             wr_dp
);

  // prio = 1 favours B on the next contested cycle
  logic prio;

  always_comb begin
    grant_a = a_valid && (!b_valid || !prio);
    grant_b = b_valid && (!a_valid ||  prio);
    wr_en   = (grant_a || grant_b) && !rst;
    wr_idx  = grant_b ? b_idx  : a_idx;
    wr_data = grant_b ? b_data : a_data;
    wr_dp   = grant_b ? b_dp   : a_dp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (a_valid && b_valid) begin
      prio <= ~prio;
    end
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// 8-digit multiplexed seven-segment scan controller with a dual-requester digit buffer.
// Optional leading-zero blanking: define SEG_LZ_BLANK_EN.
module seg_scan_scheduler
  import seg_scan_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 12_500,
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic                  CLK100MHZ,
  input  logic                  RST,
  input  logic [NUM_DIGITS-1:0] digit_en,
  seg_scan_scheduler_if.slave   wr,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  CA,
  output logic                  CB,
  output logic                  CC,
  output logic                  CD,
  output logic                  CE,
  output logic                  CF,
  output logic                  CG,
  output logic                  DP
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

  logic             grant_a;
  logic             grant_b;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_data;
  logic             wr_dp;

  seg_write_arbiter u_arb (
    .clk     (CLK100MHZ),
    .rst     (RST),
    .a_valid (wr.a_valid),
    .a_idx   (wr.a_idx),
    .a_data  (wr.a_data),
    .a_dp    (wr.a_dp),
    .b_valid (wr.b_valid),
    .b_idx   (wr.b_idx),
    .b_data  (wr.b_data),
    .b_dp    (wr.b_dp),
    .grant_a (grant_a),
    .grant_b (grant_b),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_dp   (wr_dp)
  );

  assign wr.a_ready = grant_a;
  assign wr.b_ready = grant_b;

  seg_entry_t buffer [NUM_DIGITS];

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      buffer <= '{default: '0};
    end else if (wr_en) begin
      buffer[wr_idx] <= '{data: wr_data, dp: wr_dp};
    end
  end

  logic [NUM_DIGITS-1:0] visible;

`ifdef SEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_dark;

  // Walk from the top digit down; digit 0 is never part of the leading-zero run.
  always_comb begin
    logic             zero_run;
    logic [IDX_W-1:0] i;
    zero_run = 1'b1;
    lz_dark  = '0;
    i        = '0;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      i          = IDX_W'(NUM_DIGITS - 1 - k);
      zero_run   = zero_run && (buffer[i].data == 4'h0);
      lz_dark[i] = zero_run && !buffer[i].dp;
    end
  end

  assign visible = digit_en & ~lz_dark;
`else
  assign visible = digit_en;
`endif

  scan_state_t           state;
  logic [IDX_W-1:0]      slot;
  logic [PW-1:0]         presc;
  logic [NUM_DIGITS-1:0] an_sel;
  seg_entry_t            cur;
  logic [6:0]            seg;

  always_comb begin
    an_sel       = '1;
    an_sel[slot] = 1'b0;
    cur          = buffer[slot];
  end

  // Pins are registered from the pre-edge state, giving one cycle of latency.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state <= BLANK;
      slot  <= '0;
      presc <= '0;
      AN    <= '1;
      seg   <= '1;
      DP    <= 1'b1;
    end else begin
      AN  <= '1;
      seg <= '1;
      DP  <= 1'b1;
      if (state == DRIVE && visible[slot]) begin
        AN  <= an_sel;
        seg <= hex_to_seg(cur.data);
        DP  <= ~cur.dp;
      end

      if (presc == PRESC_LAST) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      case (state)
        BLANK: begin
          if (presc == BLANK_LAST) begin
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (presc == PRESC_LAST) begin
            state <= BLANK;
            slot  <= slot + 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler (TICK_DIV=20, BLANK_CYCLES=4); honours SEG_LZ_BLANK_EN.
module tb_seg_scan_scheduler;

  logic       CLK100MHZ = 1'b0;
  logic       RST;
  logic [7:0] digit_en;
  logic [7:0] AN;
  logic       CA, CB, CC, CD, CE, CF, CG, DP;
  logic [6:0] seg;

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;

  seg_scan_scheduler_if wr ();

  seg_scan_scheduler #(
    .TICK_DIV     (20),
    .BLANK_CYCLES (4)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .RST       (RST),
    .digit_en  (digit_en),
    .wr        (wr),
    .AN        (AN),
    .CA        (CA),
    .CB        (CB),
    .CC        (CC),
    .CD        (CD),
    .CE        (CE),
    .CF        (CF),
    .CG        (CG),
    .DP        (DP)
  );

  assign seg = {CA, CB, CC, CD, CE, CF, CG};

  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
    t++;
  endtask

  task automatic wait_until(input int target);
    while (t < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic chk_pins(input string tag, input logic [7:0] an_e, input logic [6:0] seg_e, input logic dp_e);
    chk({tag, ".AN"}, AN, an_e);
    chk({tag, ".SEG"}, seg, seg_e);
    chk({tag, ".DP"}, DP, dp_e);
  endtask

  initial begin
    RST        = 1'b1;
    digit_en   = 8'hFF;
    wr.a_valid = 1'b0;
    wr.a_idx   = '0;
    wr.a_data  = '0;
    wr.a_dp    = 1'b0;
    wr.b_valid = 1'b0;
    wr.b_idx   = '0;
    wr.b_data  = '0;
    wr.b_dp    = 1'b0;

    // Reset state; a write offered during reset is granted but must be dropped
    tick();
    tick();
    chk_pins("rst", 8'hFF, 7'h7F, 1'b1);
    chk("rst.a_ready_idle", wr.a_ready, 1'b0);
    wr.a_valid = 1'b1;
    wr.a_idx   = 3'd0;
    wr.a_data  = 4'h8;
    #1;
    chk("rst.a_ready_follow", wr.a_ready, 1'b1);
    tick();
    RST        = 1'b0;
    wr.a_valid = 1'b0;
    t          = 0;

    // Scan after reset
    wait_until(4);
    chk_pins("blank0", 8'hFF, 7'h7F, 1'b1);
    wait_until(5);
    chk_pins("drive0", 8'hFE, 7'h01, 1'b1);
    wait_until(20);
    chk("drive0_end.AN", AN, 8'hFE);
    wait_until(21);
    chk("blank1.AN", AN, 8'hFF);
    wait_until(25);
    chk_pins("drive1", 8'hFD, 7'h01, 1'b1);
    wait_until(164);
    chk("wrap_blank.AN", AN, 8'hFF);
    wait_until(165);
    chk_pins("wrap_drive0", 8'hFE, 7'h01, 1'b1);

    // A writes digit 3 = 4 with dp while digit 3 is being driven
    wait_until(229);
    chk_pins("d3_before", 8'hF7, 7'h01, 1'b1);
    wr.a_valid = 1'b1;
    wr.a_idx   = 3'd3;
    wr.a_data  = 4'h4;
    wr.a_dp    = 1'b1;
    #1;
    chk("wrA.a_ready", wr.a_ready, 1'b1);
    tick();
    wr.a_valid = 1'b0;
    wr.a_dp    = 1'b0;
    chk_pins("d3_accept_edge", 8'hF7, 7'h01, 1'b1);
    tick();
    chk_pins("d3_after", 8'hF7, 7'h4C, 1'b0);

    // Contested writes to digit 2: A=5, B=6 held for four cycles
    wr.a_valid = 1'b1;
    wr.a_idx   = 3'd2;
    wr.a_data  = 4'h5;
    wr.b_valid = 1'b1;
    wr.b_idx   = 3'd2;
    wr.b_data  = 4'h6;
    wr.b_dp    = 1'b0;
    #1;
    chk("rr1.a_ready", wr.a_ready, 1'b1);
    chk("rr1.b_ready", wr.b_ready, 1'b0);
    tick();
    chk("rr2.a_ready", wr.a_ready, 1'b0);
    chk("rr2.b_ready", wr.b_ready, 1'b1);
    tick();
    chk("rr3.a_ready", wr.a_ready, 1'b1);
    chk("rr3.b_ready", wr.b_ready, 1'b0);
    tick();
    chk("rr4.a_ready", wr.a_ready, 1'b0);
    chk("rr4.b_ready", wr.b_ready, 1'b1);
    tick();
    wr.a_valid = 1'b0;
    wr.b_valid = 1'b0;

    wait_until(370);
    chk_pins("d2_is6", 8'hFB, 7'h20, 1'b1);
    wait_until(390);
    chk_pins("d3_kept", 8'hF7, 7'h4C, 1'b0);

    // Only digits 0..3 enabled
    digit_en = 8'h0F;
    wait_until(490);
    chk_pins("en_d0", 8'hFE, 7'h01, 1'b1);
    wait_until(550);
    chk_pins("en_d3", 8'hF7, 7'h4C, 1'b0);
    wait_until(570);
    chk_pins("dis_d4", 8'hFF, 7'h7F, 1'b1);
    wait_until(590);
    chk("dis_d5.AN", AN, 8'hFF);
    wait_until(630);
    chk("dis_d7.AN", AN, 8'hFF);
    digit_en = 8'hFF;

    // Reset in the middle of slot 5 drive, with a write that must be dropped
    wait_until(750);
    chk_pins("d5_pre_rst", 8'hDF, 7'h01, 1'b1);
    RST        = 1'b1;
    wr.a_valid = 1'b1;
    wr.a_idx   = 3'd1;
    wr.a_data  = 4'h9;
    wr.a_dp    = 1'b1;
    #1;
    chk("rst2.a_ready", wr.a_ready, 1'b1);
    tick();
    chk_pins("rst2_dark", 8'hFF, 7'h7F, 1'b1);
    RST        = 1'b0;
    wr.a_valid = 1'b0;
    wr.a_dp    = 1'b0;
    wait_until(755);
    chk("rst2_blank.AN", AN, 8'hFF);
    wait_until(756);
    chk_pins("rst2_d0", 8'hFE, 7'h01, 1'b1);
    wait_until(776);
    chk_pins("rst2_d1_dropped", 8'hFD, 7'h01, 1'b1);
    wait_until(796);
    chk_pins("rst2_d2_clear", 8'hFB, 7'h01, 1'b1);
    wait_until(816);
    chk_pins("rst2_d3_clear", 8'hF7, 7'h01, 1'b1);

    // Buffer 7..0 = 0,0,0,0,0,1,2,3
    wr.a_valid = 1'b1;
    wr.a_idx   = 3'd0;
    wr.a_data  = 4'h3;
    tick();
    wr.a_idx   = 3'd1;
    wr.a_data  = 4'h2;
    tick();
    wr.a_idx   = 3'd2;
    wr.a_data  = 4'h1;
    tick();
    wr.a_valid = 1'b0;

    wait_until(921);
    chk_pins("lz_d0", 8'hFE, 7'h06, 1'b1);
    wait_until(941);
    chk_pins("lz_d1", 8'hFD, 7'h12, 1'b1);
    wait_until(961);
    chk_pins("lz_d2", 8'hFB, 7'h4F, 1'b1);
    wait_until(981);
`ifdef SEG_LZ_BLANK_EN
    chk_pins("lz_d3", 8'hFF, 7'h7F, 1'b1);
`else
    chk_pins("lz_d3", 8'hF7, 7'h01, 1'b1);
`endif
    wait_until(1061);
`ifdef SEG_LZ_BLANK_EN
    chk_pins("lz_d7", 8'hFF, 7'h7F, 1'b1);
`else
    chk_pins("lz_d7", 8'h7F, 7'h01, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
